main_memory: RTL and testbench
==============================

# main_memory

Main-memory model and controller directly downstream of `cache_top`. Serves block refills (4-word line read) and write-through single-word writes with a fixed multi-cycle latency and a one-cycle `Ready` pulse. The cache raises `stall` toward the core while a request here is outstanding.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: word address width; memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width.
- `WORDS_PER_BLOCK`, 4: words per cache line; power of two, ≥2.
- `LATENCY`, 4: cycles from request acceptance to `Ready`; ≥1.

Ports:
- `CLK`, in, 1: clock; rising edge active.
- `RST`, in, 1: one clock; reset is asynchronous and active-low.
- `MemRead`, in, 1: block read request from the cache.
- `MemWrite`, in, 1: word write request from the cache.
- `Address`, in, ADDR_WIDTH: word address. Reads ignore the low log2(WORDS_PER_BLOCK) bits.
- `DataIn`, in, DATA_WIDTH: write data.
- `Ready`, out, 1: one-cycle pulse when the accepted request completes.
- `DataOut`, out, DATA_WIDTH*WORDS_PER_BLOCK: read block. Word i is in bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation

- Storage: 2^ADDR_WIDTH × DATA_WIDTH array. Contents are not cleared by reset.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `MemWrite` or `MemRead` is high at a rising edge, the request is accepted:
    - latch op, `Address` and `DataIn`;
    - load the counter with LATENCY-1;
    - go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY: counter decrements each edge. On the edge where the counter is 0 (counter value before the edge):
    - commit the op;
    - set `Ready` to 1;
    - go to DONE.
  - DONE: `Ready` returns to 0; go to IDLE. Request inputs are ignored in DONE.
- Commit, write: mem[latched address] ← latched data. `DataOut` is unchanged.
- Commit, read: base = latched address with the low offset bits zeroed. `DataOut` word i ← mem[base + i] for i = 0..WORDS_PER_BLOCK-1. `DataOut` holds this value until the next read commits.
- Both `MemRead` and `MemWrite` high at acceptance: treated as a write; the read is dropped.
- Inputs are sampled only at acceptance. Changes to them during BUSY/DONE have no effect.
- The requester must keep the request high until it sees `Ready`. It must drop or change the request in the cycle after `Ready`, or it will be re-accepted as a new request.
- Address arithmetic: the block base is ADDR_WIDTH wide, and block words never cross a block boundary. Address 0x3FF reads words 0x3FC..0x3FF; no wrap past the array top.

## Timing

- Reset (asynchronous, `RST`=0):
  - state IDLE, counter 0, `Ready`=0, `DataOut`=0, latched registers 0;
  - an in-flight op is aborted and no write is committed;
  - on release, the first acceptance can occur at the first rising edge with `RST`=1.
- Latency: request accepted at edge E0 → `Ready` high from edge E0+LATENCY to E0+LATENCY+1, exactly one cycle.
- `DataOut` is valid in the same cycle as the `Ready` pulse and stays valid afterwards.
- A written word is readable by any request accepted after the write's `Ready` pulse.
- Throughput: one request per LATENCY+2 cycles when requests are held continuously.
- LATENCY=1: BUSY lasts one cycle; the counter is loaded with 0.
- `Ready` and `DataOut` are registered outputs with no combinational path from the inputs.

## Test plan

- Reset: drive `RST`=0 mid-BUSY of a write to 0x010 with data 0xDEAD, then read block 0x010. Required: `Ready`=0 and `DataOut`=0 immediately; the write is not committed; the read returns the pre-reset contents of 0x010.
- Write then read: write 0x3FF←0x3FF, 0x3FE←0x3FE, 0x3FD←0x3FD, 0x3FC←0x3FC, then read 0x3FD. Required:
  - `Ready` pulses LATENCY edges after each acceptance;
  - `DataOut` = {0x3FF, 0x3FE, 0x3FD, 0x3FC}, with word 3 in the MSBs.
- Held request: hold `MemWrite`=1 at 0x005 for 20 cycles with LATENCY=4. Required: `Ready` pulses every 6 cycles, one cycle wide, and the final mem[0x005] equals `DataIn` at the last acceptance.
- Simultaneous `MemRead`=`MemWrite`=1 at 0x020 with data 0x1234. Required:
  - a write commits;
  - `DataOut` keeps its prior value;
  - a later read of block 0x020 returns word 0 = 0x1234.
- Input change during BUSY: accept a read at 0x3F8, then switch `Address` to 0x000 during BUSY. Required: `DataOut` = block 0x3F8..0x3FB.
- LATENCY=1 build: write 0x001←0xA5, then read 0x000. Required: `Ready` one edge after each acceptance, and `DataOut` word 1 = 0xA5.

Source files
------------

// File: rtl/main_memory.sv
// Main-memory model behind the cache: block refills and single-word write-through with a
// fixed request-to-Ready latency and a one-cycle Ready pulse.
module main_memory #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  MemRead,
  input  logic                                  MemWrite,
  input  logic [ADDR_WIDTH-1:0]                 Address,
  input  logic [DATA_WIDTH-1:0]                 DataIn,
  output logic                                  Ready,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] DataOut
);

  localparam int unsigned Depth   = 1 << ADDR_WIDTH;
  localparam int unsigned OffW    = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned BlockW  = DATA_WIDTH * WORDS_PER_BLOCK;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                stateQ, stateD;
  logic [CntW-1:0]       cntQ, cntD;
  logic                  opWriteQ, opWriteD;
  logic [ADDR_WIDTH-1:0] addrQ, addrD;
  logic [DATA_WIDTH-1:0] dataQ, dataD;
  logic                  readyQ, readyD;
  logic [BlockW-1:0]     dataOutQ;
  logic [BlockW-1:0]     readBlock;
  logic                  commit;

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [Depth];

  // Next-state logic: accept in idle, count down in busy, one-cycle Ready in done.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    opWriteD = opWriteQ;
    addrD    = addrQ;
    dataD    = dataQ;
    readyD   = 1'b0;
    commit   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (MemWrite || MemRead) begin
          // A simultaneous read+write is a write; the read is dropped.
          opWriteD = MemWrite;
          addrD    = Address;
          dataD    = DataIn;
          cntD     = CntLoad;
          stateD   = StBusy;
        end
      end
      StBusy: begin
        if (cntQ == '0) begin
          commit = 1'b1;
          readyD = 1'b1;
          stateD = StDone;
        end else begin
          cntD = cntQ - CntW'(1);
        end
      end
      StDone: begin
        // Request inputs ignored here so a held request is not re-accepted early.
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Gather the aligned block around the latched address; words never cross the block.
  always_comb begin
    readBlock = '0;
    for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
      readBlock[i*DATA_WIDTH +: DATA_WIDTH] = mem[{addrQ[ADDR_WIDTH-1:OffW], OffW'(i)}];
    end
  end

  // Control and output registers; reset aborts any in-flight op.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      opWriteQ <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
      readyQ   <= 1'b0;
      dataOutQ <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      opWriteQ <= opWriteD;
      addrQ    <= addrD;
      dataQ    <= dataD;
      readyQ   <= readyD;
      if (commit && !opWriteQ) begin
        dataOutQ <= readBlock;
      end
    end
  end

  // Write commit; commit is low while reset holds the FSM in idle.
  always_ff @(posedge CLK) begin
    if (commit && opWriteQ) begin
      mem[addrQ] <= dataQ;
    end
  end

  assign Ready   = readyQ;
  assign DataOut = dataOutQ;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed scenarios plus random traffic against an
// array-based reference model.
module tb_main_memory;

  localparam int Lat = 4;

  logic         CLK;
  logic         RST;
  logic         MemRead, MemWrite;
  logic [9:0]   Address;
  logic [31:0]  DataIn;
  logic         Ready;
  logic [127:0] DataOut;

  logic         rd1, wr1;
  logic [9:0]   addr1;
  logic [31:0]  din1;
  logic         ready1;
  logic [127:0] dout1;

  int total;
  int bad;

  logic [31:0]  model [1024];
  logic [127:0] expOut;

  main_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WORDS_PER_BLOCK(4), .LATENCY(Lat)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .DataIn(DataIn), .Ready(Ready), .DataOut(DataOut)
  );

  main_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WORDS_PER_BLOCK(4), .LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST), .MemRead(rd1), .MemWrite(wr1), .Address(addr1),
    .DataIn(din1), .Ready(ready1), .DataOut(dout1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] refBlock(input logic [9:0] a);
    logic [127:0] r;
    int unsigned base;
    base = (int'(a) / 4) * 4;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = model[base + i];
    return r;
  endfunction

  // One request, entered just after a rising edge; returns one cycle after Ready.
  task automatic req(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d,
                     input bit scramble);
    MemRead = rd; MemWrite = wr; Address = a; DataIn = d;
    @(posedge CLK); #1;
    if (scramble) begin
      Address = 10'h000;
      DataIn  = $urandom;
    end
    for (int k = 1; k <= Lat; k++) begin
      @(posedge CLK); #1;
      check("ready_timing", {127'b0, Ready}, {127'b0, k == Lat});
    end
    if (wr) model[a] = d;
    else expOut = refBlock(a);
    check("dataout", DataOut, expOut);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge CLK); #1;
    check("ready_drop", {127'b0, Ready}, 128'b0);
    check("dataout_hold", DataOut, expOut);
  endtask

  initial begin
    int nextFree;
    int readyAt;
    logic [31:0] lastData;
    logic [127:0] want;
    int op;

    total = 0; bad = 0;
    RST = 1'b0;
    MemRead = 0; MemWrite = 0; Address = '0; DataIn = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; din1 = '0;
    expOut = '0;
    #22;
    check("reset_ready", {127'b0, Ready}, 128'b0);
    check("reset_dataout", DataOut, 128'b0);
    check("reset_ready_l1", {127'b0, ready1}, 128'b0);
    check("reset_dataout_l1", dout1, 128'b0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;

    // LATENCY=1 instance: write then read, Ready one edge after acceptance.
    wr1 = 1; addr1 = 10'h001; din1 = 32'hA5;
    @(posedge CLK); #1;
    check("l1_wr_busy", {127'b0, ready1}, 128'b0);
    @(posedge CLK); #1;
    check("l1_wr_ready", {127'b0, ready1}, 128'b1);
    wr1 = 0;
    @(posedge CLK); #1;
    check("l1_wr_drop", {127'b0, ready1}, 128'b0);
    rd1 = 1; addr1 = 10'h000;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("l1_rd_ready", {127'b0, ready1}, 128'b1);
    check("l1_rd_word1", {96'b0, dout1[63:32]}, {96'b0, 32'hA5});
    rd1 = 0;
    @(posedge CLK); #1;
    check("l1_rd_drop", {127'b0, ready1}, 128'b0);

    // Fill regions used by later reads.
    for (int i = 0; i < 64; i++) req(1'b0, 1'b1, 10'(i), $urandom, 1'b0);
    for (int i = 10'h3F0; i < 10'h3FC; i++) req(1'b0, 1'b1, 10'(i), $urandom, 1'b0);

    // Write top of array, read back an unaligned address in that block.
    for (int i = 10'h3FF; i >= 10'h3FC; i--) req(1'b0, 1'b1, 10'(i), 32'(i), 1'b0);
    req(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b0);
    want = {32'h3FF, 32'h3FE, 32'h3FD, 32'h3FC};
    check("top_block", DataOut, want);

    // Reset in the middle of a write: nothing committed, outputs cleared.
    MemWrite = 1; Address = 10'h010; DataIn = 32'hDEAD;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("midreset_ready", {127'b0, Ready}, 128'b0);
    check("midreset_dataout", DataOut, 128'b0);
    expOut = '0;
    MemWrite = 0;
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    req(1'b1, 1'b0, 10'h010, 32'h0, 1'b0);
    check("midreset_no_commit", {96'b0, DataOut[31:0]}, {96'b0, model[10'h010]});

    // Held write request: re-accepted every Lat+2 cycles.
    nextFree = 1; readyAt = -1; lastData = '0;
    MemWrite = 1; Address = 10'h005; DataIn = $urandom;
    for (int k = 1; k <= 24; k++) begin
      if (k <= 20 && k >= nextFree) begin
        lastData = DataIn;
        readyAt  = k + Lat;
        nextFree = k + Lat + 2;
      end
      @(posedge CLK); #1;
      check("held_ready", {127'b0, Ready}, {127'b0, k == readyAt});
      if (k < 20) DataIn = $urandom;
      else if (k == 20) MemWrite = 0;
    end
    model[10'h005] = lastData;
    req(1'b1, 1'b0, 10'h005, 32'h0, 1'b0);
    check("held_final", {96'b0, DataOut[63:32]}, {96'b0, lastData});

    // Inputs changed during busy must not matter.
    req(1'b1, 1'b0, 10'h3F8, 32'h0, 1'b1);
    check("busy_change", DataOut, refBlock(10'h3F8));

    // Simultaneous read+write acts as a write only.
    want = DataOut;
    req(1'b1, 1'b1, 10'h020, 32'h1234, 1'b0);
    check("both_keep_dataout", DataOut, want);
    req(1'b1, 1'b0, 10'h020, 32'h0, 1'b0);
    check("both_committed", {96'b0, DataOut[31:0]}, {96'b0, 32'h1234});

    // Random traffic within the initialised low region.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      req(op != 1, op != 0, 10'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
